// File: rtl/bip_control_unit.sv
// bip_control_unit: FETCH/DECODE/EXEC control FSM for the accumulator datapath, one instruction per 3 cycles.
// Optional undefined-opcode trap enabled by defining BIP_ILLEGAL_TRAP_EN (default build runs undefined opcodes as NOP).
module bip_control_unit #(
   parameter int OP_BITS  = 5,
   parameter int S_BITS   = 2,
   parameter int CNT_BITS = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [OP_BITS-1:0]  i_opcode,
   output logic                o_fetch,
   output logic [S_BITS-1:0]   o_sel_a,
   output logic                o_sel_b,
   output logic                o_op,
   output logic                o_wr_acc,
   output logic                o_rd_ram,
   output logic                o_wr_ram,
   output logic                o_pc_en,
   output logic                o_halt,
   output logic                o_illegal,
   output logic [CNT_BITS-1:0] o_instr_cnt
);
`ifdef BIP_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
   state_t state_q, state_d;
   logic [OP_BITS-1:0] ir_q, ir_d, opc;
   logic is_hlt, is_sto, is_ld, is_ldi, is_undef, is_alu, stop;
   logic [S_BITS-1:0] dec_sel_a, sel_a_d;
   logic dec_sel_b, dec_sub, dec_rd, dec_wr_acc;
   logic fetch_d, sel_b_d, op_d, wr_acc_d, rd_ram_d, wr_ram_d, pc_en_d, halt_d, illegal_d;
   logic [CNT_BITS-1:0] cnt_d;
   // Decode the live opcode while fetching so selects are registered at the end of FETCH; otherwise the IR.
   assign opc        = (state_q == FETCH) ? i_opcode : ir_q;
   assign is_hlt     = opc == OP_BITS'(0);
   assign is_sto     = opc == OP_BITS'(1);
   assign is_ld      = opc == OP_BITS'(2);
   assign is_ldi     = opc == OP_BITS'(3);
   assign is_undef   = opc > OP_BITS'(7);
   assign is_alu     = !is_undef && opc[2];
   assign dec_sel_a  = is_ldi ? S_BITS'(1) : is_alu ? S_BITS'(2) : '0;
   assign dec_sel_b  = is_alu & opc[0];
   assign dec_sub    = is_alu & opc[1];
   assign dec_rd     = is_ld | (is_alu & ~opc[0]);
   assign dec_wr_acc = is_ld | is_ldi | is_alu;
   assign stop       = is_hlt | (TRAP & is_undef);
   // Next state and next registered outputs; everything defaults to idle/zero.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      fetch_d   = 1'b0;
      sel_a_d   = '0;
      sel_b_d   = 1'b0;
      op_d      = 1'b0;
      rd_ram_d  = 1'b0;
      wr_acc_d  = 1'b0;
      wr_ram_d  = 1'b0;
      pc_en_d   = 1'b0;
      halt_d    = 1'b0;
      illegal_d = o_illegal;
      cnt_d     = o_instr_cnt;
      case (state_q)
         FETCH: begin
            state_d = o_fetch ? DECODE : FETCH;
            fetch_d = !o_fetch;
            if (o_fetch) begin
               ir_d     = i_opcode;
               sel_a_d  = dec_sel_a;
               sel_b_d  = dec_sel_b;
               op_d     = dec_sub;
               rd_ram_d = dec_rd;
            end
         end
         DECODE: begin
            if (stop) begin
               state_d   = HALT;
               halt_d    = 1'b1;
               illegal_d = TRAP & is_undef;
            end else begin
               state_d  = EXEC;
               sel_a_d  = o_sel_a;
               sel_b_d  = o_sel_b;
               op_d     = o_op;
               rd_ram_d = o_rd_ram;
               wr_acc_d = dec_wr_acc;
               wr_ram_d = is_sto;
               pc_en_d  = 1'b1;
               cnt_d    = o_instr_cnt + CNT_BITS'(1);
            end
         end
         EXEC: begin
            state_d = FETCH;
            fetch_d = 1'b1;
         end
         default: halt_d = 1'b1;
      endcase
   end
   // State, instruction register and all outputs; async reset clears everything immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= FETCH;
         ir_q        <= '0;
         o_fetch     <= 1'b0;
         o_sel_a     <= '0;
         o_sel_b     <= 1'b0;
         o_op        <= 1'b0;
         o_rd_ram    <= 1'b0;
         o_wr_acc    <= 1'b0;
         o_wr_ram    <= 1'b0;
         o_pc_en     <= 1'b0;
         o_halt      <= 1'b0;
         o_illegal   <= 1'b0;
         o_instr_cnt <= '0;
      end else begin
         state_q     <= state_d;
         ir_q        <= ir_d;
         o_fetch     <= fetch_d;
         o_sel_a     <= sel_a_d;
         o_sel_b     <= sel_b_d;
         o_op        <= op_d;
         o_rd_ram    <= rd_ram_d;
         o_wr_acc    <= wr_acc_d;
         o_wr_ram    <= wr_ram_d;
         o_pc_en     <= pc_en_d;
         o_halt      <= halt_d;
         o_illegal   <= illegal_d;
         o_instr_cnt <= cnt_d;
      end
   end
endmodule

// File: tb/tb_bip_control_unit.sv
// tb_bip_control_unit: random + directed opcode stream, instruction-level reference model and scoreboard.
module tb_bip_control_unit;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic [4:0]  i_opcode = '0;
   logic        o_fetch, o_sel_b, o_op, o_wr_acc, o_rd_ram, o_wr_ram, o_pc_en, o_halt, o_illegal;
   logic [1:0]  o_sel_a;
   logic [15:0] o_instr_cnt;

   bip_control_unit dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opcode(i_opcode), .o_fetch(o_fetch),
      .o_sel_a(o_sel_a), .o_sel_b(o_sel_b), .o_op(o_op), .o_wr_acc(o_wr_acc),
      .o_rd_ram(o_rd_ram), .o_wr_ram(o_wr_ram), .o_pc_en(o_pc_en), .o_halt(o_halt),
      .o_illegal(o_illegal), .o_instr_cnt(o_instr_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [1:0]  sel_a;
      logic        sel_b, sub, rd, wr_ram, wr_acc, halt, illegal;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0, errors = 0, model_cnt = 0;
   bit   halted = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Instruction table: what each opcode should make the control unit do.
   function automatic exp_t spec(input logic [4:0] op);
      exp_t e = '0;
      case (op)
         5'd0: e.halt = 1;
         5'd1: e.wr_ram = 1;
         5'd2: begin e.rd = 1; e.wr_acc = 1; end
         5'd3: begin e.sel_a = 2'b01; e.wr_acc = 1; end
         5'd4: begin e.sel_a = 2'b10; e.rd = 1; e.wr_acc = 1; end
         5'd5: begin e.sel_a = 2'b10; e.sel_b = 1; e.wr_acc = 1; end
         5'd6: begin e.sel_a = 2'b10; e.sub = 1; e.rd = 1; e.wr_acc = 1; end
         5'd7: begin e.sel_a = 2'b10; e.sel_b = 1; e.sub = 1; e.wr_acc = 1; end
         default: begin
`ifdef BIP_ILLEGAL_TRAP_EN
            e.halt = 1;
            e.illegal = 1;
`endif
         end
      endcase
      return e;
   endfunction

   // Monitor: checks DECODE selects against the head of the queue and pops at EXEC or at entry to HALT.
   initial begin
      exp_t e;
      logic prev_fetch = 0, prev_halt = 0;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            prev_fetch = 0;
            prev_halt = 0;
         end else begin
            if (o_fetch)
               chk("fetch_clear", {o_sel_a, o_sel_b, o_op, o_rd_ram, o_wr_acc, o_wr_ram, o_pc_en, o_halt}, 0);
            if (prev_fetch) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL decode: DUT decoding with no instruction expected");
               end else begin
                  e = q[0];
                  chk("decode", {o_fetch, o_sel_a, o_sel_b, o_op, o_rd_ram, o_wr_acc, o_wr_ram, o_pc_en, o_halt},
                      {1'b0, e.sel_a, e.sel_b, e.sub, e.rd, 4'b0});
               end
            end
            if (o_pc_en) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL exec: unexpected pc_en pulse");
               end else begin
                  e = q.pop_front();
                  chk("exec", {o_pc_en, o_sel_a, o_sel_b, o_op, o_rd_ram, o_wr_acc, o_wr_ram, o_halt, o_illegal, o_fetch},
                      {~e.halt, e.sel_a, e.sel_b, e.sub, e.rd, e.wr_acc, e.wr_ram, 3'b0});
                  chk("exec_cnt", o_instr_cnt, e.cnt);
               end
            end else if (o_halt && !prev_halt) begin
               if (q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL halt: unexpected halt");
               end else begin
                  e = q.pop_front();
                  chk("halt", {o_halt, o_illegal, o_pc_en, o_wr_acc, o_wr_ram, o_fetch}, {e.halt, e.illegal, 4'b0});
                  chk("halt_cnt", o_instr_cnt, e.cnt);
               end
            end else if (o_halt) begin
               chk("halt_quiet", {o_fetch, o_pc_en, o_wr_acc, o_wr_ram, o_sel_a, o_sel_b, o_op, o_rd_ram}, 0);
            end
            prev_fetch = o_fetch;
            prev_halt = o_halt;
         end
      end
   end

   task automatic check_all_zero(input string name);
      chk(name, {o_fetch, o_sel_a, o_sel_b, o_op, o_wr_acc, o_rd_ram, o_wr_ram, o_pc_en, o_halt, o_illegal, o_instr_cnt}, 0);
   endtask

   task automatic do_reset();
      #1 i_rst_n = 1'b0;
      #1 check_all_zero("reset_outputs");
      q.delete();
      model_cnt = 0;
      halted = 0;
      @(negedge i_clk);
      @(negedge i_clk);
      #1 i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("fetch_after_reset", {o_fetch, o_instr_cnt}, {1'b1, 16'h0});
   endtask

   task automatic wait_fetch();
      int n = 0;
      while (!o_fetch && n < 8) begin
         i_opcode = 5'($urandom);
         @(negedge i_clk);
         n++;
      end
      if (!o_fetch) begin
         checks++; errors++;
         $display("FAIL fetch_timeout: o_fetch 0 expected 1");
      end
   endtask

   task automatic halt_phase();
      repeat (6) begin
         i_opcode = 5'd4;
         @(negedge i_clk);
      end
      chk("halt_hold", {o_halt, o_fetch, o_pc_en}, 3'b100);
      chk("halt_cnt_hold", o_instr_cnt, 16'(model_cnt));
      do_reset();
   endtask

   task automatic issue(input logic [4:0] op);
      exp_t e;
      wait_fetch();
      i_opcode = op;
      e = spec(op);
      if (!e.halt) model_cnt++;
      e.cnt = 16'(model_cnt);
      if (e.halt) halted = 1;
      q.push_back(e);
      @(negedge i_clk);
      if (halted) halt_phase();
   endtask

   initial begin
      int n;
      logic [4:0] op;
      repeat (2) @(negedge i_clk);
      do_reset();
      issue(5'd3);
      issue(5'd2);
      issue(5'd4);
      issue(5'd7);
      issue(5'd1);
      issue(5'd0);
      issue(5'd31);
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
         issue(op);
      end
      n = 0;
      while (q.size() != 0 && n < 6) begin
         @(negedge i_clk);
         n++;
      end
      chk("drain", q.size(), 0);
      issue(5'd4);
      @(posedge i_clk);
      #2 chk("exec_before_reset", {o_pc_en, o_wr_acc}, 2'b11);
      i_rst_n = 1'b0;
      #1 check_all_zero("reset_mid_exec");
      q.delete();
      model_cnt = 0;
      @(posedge i_clk);
      #1 check_all_zero("no_pending_strobe");
      @(negedge i_clk);
      #1 i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("fetch_after_mid_reset", {o_fetch, o_instr_cnt, o_pc_en}, {1'b1, 16'h0, 1'b0});
      i_rst_n = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
